puf_response_engine: RTL and testbench
======================================

# puf_response_engine

Sequencing controller for a parametrised arbiter PUF. It expands one seed challenge into RESP_BITS challenges, fires the arbiter chain VOTES times per challenge, and majority-votes each sampled race result into one response bit. It also flags response bits whose votes disagreed. It sits between the tile's I/O logic and the arbiter delay chain and replaces direct pulse/challenge driving of the PUF.

## Interface
- CH_W, 8: challenge width (bits into the arbiter chain)
- RESP_BITS, 8: response bits produced per request
- VOTES, 5: evaluations per response bit; must be odd, ≥1
- SETTLE, 4: cycles arb_launch is held high before sampling; ≥1
- CH_STEP, 8'h3B: challenge increment per response bit; odd, CH_W bits

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- seed  in  CH_W  base challenge, captured when start is accepted
- arb_resp  in  1  arbiter output (already latched by the arbiter)
- arb_challenge  out  CH_W  challenge driven to the delay chain
- arb_launch  out  1  race launch; its rising edge starts a race
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the response is valid
- response  out  RESP_BITS  majority-voted response; bit k from challenge k
- unstable  out  RESP_BITS  bit k set if the votes for bit k were not unanimous

## Operation
- Reset value of all outputs and state is 0, state IDLE.
- Challenge k is (seed + k·CH_STEP) mod 2^CH_W, for k = 0..RESP_BITS-1.
- States:
  - IDLE: if start=1, capture seed, clear response and unstable, set k=0, vote=0, ones=0, go to ARM.
  - ARM (1 cycle): arb_challenge = challenge k, arb_launch=0.
  - FIRE (SETTLE cycles): arb_launch=1, challenge held.
  - SAMPLE (1 cycle): arb_launch=0. If arb_resp is 1, increment ones; increment vote. If vote reaches VOTES, go to DECIDE, else go to ARM.
  - DECIDE (1 cycle): response[k] = (ones > VOTES/2); unstable[k] = (ones≠0 && ones≠VOTES). Clear ones and vote. If k=RESP_BITS-1, go to DONE, else k+1 and go to ARM.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- ones counter width: clog2(VOTES+1); no overflow possible.
- arb_challenge holds its last value in IDLE and DONE.
- start while busy is ignored, with no queuing.
- response and unstable hold after done until the next accepted start.
- Reset mid-operation aborts immediately:
  - all outputs go to 0;
  - no done pulse is issued;
  - a partial response is discarded.

## Timing
- Per vote: SETTLE+2 cycles (ARM + FIRE + SAMPLE).
- Per bit: VOTES·(SETTLE+2)+1 cycles.
- done is high in the cycle beginning at edge N = RESP_BITS·(VOTES·(SETTLE+2)+1)+1 after the edge that accepts start. With defaults, N = 249.
- busy is high for edges 1..N-1, low at N.
- arb_resp is sampled on the clock edge that ends the SAMPLE cycle, i.e. SETTLE+1 cycles after arb_launch rises.
- A new start is accepted at earliest in the IDLE cycle following DONE.
- Back-to-back start-to-start period is N+1 cycles.

## Test plan
- arb_resp tied 1, seed 0x00, defaults -> response 0xFF, unstable 0x00, single done pulse at edge 249, busy low at 249.
- seed 0xF0, arb_resp tied 0 -> arb_challenge sequence 0xF0, 0x2B, …, 0x8D (k=7); response 0x00; each challenge held exactly 30 cycles plus the DECIDE cycle.
- arb_resp = XOR-reduce(arb_challenge) modelled combinationally, seed 0x5A -> response bit k equals parity of challenge k; unstable 0x00.
- Noisy model: for k=2 only, arb_resp is 1 on votes 0, 1, 2 and 0 on votes 3, 4; elsewhere 0 -> response 0x04, unstable 0x04. Repeat with 2 ones of 5 -> response 0x00, unstable 0x04.
- Pulse start again at edges 10 and 248 -> ignored, with no change to timing or results. start at edge 250 (IDLE) -> accepted, and outputs clear at edge 251.
- Assert rst_n low asynchronously mid-clock at cycle 100 -> all outputs 0 immediately, no done. Release, then start -> a full run completes normally with done at edge 249.

Source files
------------

// File: rtl/puf_response_engine.sv
// Arbiter-PUF sequencing controller: expands one seed into RESP_BITS challenges,
// fires each one VOTES times and majority-votes the sampled race results.
module puf_response_engine #(
   parameter int              CH_W      = 8,
   parameter int              RESP_BITS = 8,
   parameter int              VOTES     = 5,
   parameter int              SETTLE    = 4,
   parameter logic [CH_W-1:0] CH_STEP   = 8'h3B
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CH_W-1:0]      seed,
   input  logic                 arb_resp,
   output logic [CH_W-1:0]      arb_challenge,
   output logic                 arb_launch,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_BITS-1:0] response,
   output logic [RESP_BITS-1:0] unstable
);

   localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int V_W = $clog2(VOTES + 1);
   localparam int S_W = $clog2(SETTLE + 1);

   localparam logic [K_W-1:0] K_LAST = K_W'(RESP_BITS - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(VOTES - 1);
   localparam logic [V_W-1:0] V_HALF = V_W'(VOTES / 2);
   localparam logic [V_W-1:0] V_ALL  = V_W'(VOTES);
   localparam logic [S_W-1:0] S_LAST = S_W'(SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_FIRE,
      S_SAMPLE,
      S_DECIDE,
      S_DONE
   } state_t;

   state_t          state, state_next;
   logic            start_q;
   logic [CH_W-1:0] seed_q;
   logic [CH_W-1:0] chal;
   logic [K_W-1:0]  k;
   logic [V_W-1:0]  vote;
   logic [V_W-1:0]  ones;
   logic [S_W-1:0]  settle_cnt;

   assign arb_challenge = chal;

   // The request is registered on entry, so the accepting edge is the one
   // that samples start and the run proper begins one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         seed_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // sees the pre-edge values of the others, independent of block order.
         start_q <= start;
         seed_q  <= seed;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first; a path that
      // leaves one unassigned would otherwise infer a latch.
      state_next = state;
      busy       = 1'b0;
      arb_launch = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE:   if (start_q) state_next = S_ARM;
         S_ARM: begin
            busy       = 1'b1;
            state_next = S_FIRE;
         end
         S_FIRE: begin
            busy       = 1'b1;
            arb_launch = 1'b1;
            if (settle_cnt == S_LAST) state_next = S_SAMPLE;
         end
         S_SAMPLE: begin
            busy       = 1'b1;
            state_next = (vote == V_LAST) ? S_DECIDE : S_ARM;
         end
         S_DECIDE: begin
            busy       = 1'b1;
            state_next = (k == K_LAST) ? S_DONE : S_ARM;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chal       <= '0;
         k          <= '0;
         vote       <= '0;
         ones       <= '0;
         settle_cnt <= '0;
         response   <= '0;
         unstable   <= '0;
      end else begin
         case (state)
            S_IDLE: if (start_q) begin
               chal     <= seed_q;
               k        <= '0;
               vote     <= '0;
               ones     <= '0;
               response <= '0;
               unstable <= '0;
            end
            S_ARM:    settle_cnt <= '0;
            S_FIRE:   settle_cnt <= settle_cnt + 1'b1;
            S_SAMPLE: begin
               vote <= vote + 1'b1;
               if (arb_resp) ones <= ones + 1'b1;
            end
            S_DECIDE: begin
               response[k] <= (ones > V_HALF);
               unstable[k] <= (ones != '0) && (ones != V_ALL);
               ones        <= '0;
               vote        <= '0;
               // The last challenge stays on the chain through DONE and IDLE.
               if (k != K_LAST) begin
                  k    <= k + 1'b1;
                  chal <= chal + CH_STEP;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_puf_response_engine.sv
// Self-checking bench for puf_response_engine: a timing/vote model checked
// every cycle, plus hand-computed literal results for each scenario.
module tb_puf_response_engine;

   localparam int         CH_W     = 8;
   localparam int         RB       = 8;
   localparam int         VOTES    = 5;
   localparam int         SETTLE   = 4;
   localparam logic [7:0] STEP     = 8'h3B;
   localparam int         VOTE_LEN = SETTLE + 2;
   localparam int         BIT_LEN  = VOTES * VOTE_LEN + 1;
   localparam int         N        = RB * BIT_LEN + 1;

   typedef enum {M_ONE, M_ZERO, M_PARITY, M_NOISY} mode_t;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [CH_W-1:0] seed;
   logic            arb_resp;
   logic [CH_W-1:0] arb_challenge;
   logic            arb_launch;
   logic            busy;
   logic            done;
   logic [RB-1:0]   response;
   logic [RB-1:0]   unstable;

   puf_response_engine dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .seed          (seed),
      .arb_resp      (arb_resp),
      .arb_challenge (arb_challenge),
      .arb_launch    (arb_launch),
      .busy          (busy),
      .done          (done),
      .response      (response),
      .unstable      (unstable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
      end
   endtask

   // Model state: the run in progress plus what the outputs held before it.
   mode_t      mode = M_ZERO;
   int         noisy_ones = 0;
   bit         model_on = 1'b0;
   int         acc_edge = 0;
   int         done_seen = 0;
   logic [7:0] seed_m = '0;
   logic [7:0] old_chal = '0, old_resp = '0, old_unst = '0;
   logic [7:0] fin_chal = '0, fin_resp = '0, fin_unst = '0;

   function automatic logic [7:0] chal_of(input int kk);
      logic [7:0] c;
      c = seed_m;
      for (int i = 0; i < kk; i++) c = c + STEP;
      return c;
   endfunction

   function automatic logic stim_bit(input int kk, input int v);
      case (mode)
         M_ONE:    return 1'b1;
         M_PARITY: return ^chal_of(kk);
         M_NOISY:  return (kk == 2) && (v < noisy_ones);
         default:  return 1'b0;
      endcase
   endfunction

   // Arbiter stand-in: holds the race result for the whole vote window.
   always @(posedge clk) begin
      int e, r, kk, p;
      #1;
      e = edge_cnt - acc_edge;
      arb_resp = 1'b0;
      if (model_on && e >= 1 && e <= N - 1) begin
         r  = e - 1;
         kk = r / BIT_LEN;
         p  = r % BIT_LEN;
         if (p < BIT_LEN - 1) arb_resp = stim_bit(kk, p / VOTE_LEN);
      end
   end

   always @(negedge clk) begin
      int         e, r, kk, p, nbits;
      logic       exp_busy, exp_done, exp_launch;
      logic [7:0] exp_chal, exp_resp, exp_unst, mask;
      if (model_on) begin
         e          = edge_cnt - acc_edge;
         exp_busy   = 1'b0;
         exp_done   = 1'b0;
         exp_launch = 1'b0;
         exp_chal   = fin_chal;
         exp_resp   = fin_resp;
         exp_unst   = fin_unst;
         if (e <= 0) begin
            exp_chal = old_chal;
            exp_resp = old_resp;
            exp_unst = old_unst;
         end else if (e < N) begin
            r          = e - 1;
            kk         = r / BIT_LEN;
            p          = r % BIT_LEN;
            exp_busy   = 1'b1;
            exp_chal   = chal_of(kk);
            exp_launch = (p < BIT_LEN - 1) && (p % VOTE_LEN >= 1) && (p % VOTE_LEN <= SETTLE);
            nbits      = (e - 1) / BIT_LEN;
            mask       = '0;
            for (int i = 0; i < nbits; i++) mask[i] = 1'b1;
            exp_resp   = fin_resp & mask;
            exp_unst   = fin_unst & mask;
         end else if (e == N) begin
            exp_done = 1'b1;
         end
         check("busy", 32'(busy), 32'(exp_busy));
         check("done", 32'(done), 32'(exp_done));
         check("arb_launch", 32'(arb_launch), 32'(exp_launch));
         check("arb_challenge", 32'(arb_challenge), 32'(exp_chal));
         check("response", 32'(response), 32'(exp_resp));
         check("unstable", 32'(unstable), 32'(exp_unst));
         if (done) done_seen++;
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Called at posedge+2; returns at posedge+2 of the accepting edge (e = 0).
   task automatic start_run(input logic [7:0] s, input mode_t m, input int n_ones);
      start = 1'b1;
      seed  = s;
      @(posedge clk);
      #1;
      old_chal   = fin_chal;
      old_resp   = fin_resp;
      old_unst   = fin_unst;
      mode       = m;
      noisy_ones = n_ones;
      seed_m     = s;
      fin_resp   = '0;
      fin_unst   = '0;
      for (int kk = 0; kk < RB; kk++) begin
         int ones;
         ones = 0;
         for (int v = 0; v < VOTES; v++) if (stim_bit(kk, v)) ones++;
         fin_resp[kk] = (ones > VOTES / 2);
         fin_unst[kk] = (ones != 0) && (ones != VOTES);
      end
      fin_chal  = chal_of(RB - 1);
      acc_edge  = edge_cnt;
      done_seen = 0;
      model_on  = 1'b1;
      #1;
      start = 1'b0;
      seed  = 8'hA5;
   endtask

   task automatic finish_run(input logic [7:0] resp_lit, input logic [7:0] unst_lit);
      int e;
      e = edge_cnt - acc_edge;
      wait_edges(N + 1 - e);
      check("response_final", 32'(response), 32'(resp_lit));
      check("unstable_final", 32'(unstable), 32'(unst_lit));
      check("done_count", 32'(done_seen), 32'd1);
   endtask

   task automatic pulse_at(input int e_target, input logic [7:0] junk);
      int e;
      e = edge_cnt - acc_edge;
      wait_edges(e_target - 1 - e);
      start = 1'b1;
      seed  = junk;
      wait_edges(1);
      start = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      seed     = '0;
      arb_resp = 1'b0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_launch", 32'(arb_launch), 32'd0);
      check("rst_challenge", 32'(arb_challenge), 32'd0);
      check("rst_response", 32'(response), 32'd0);
      check("rst_unstable", 32'(unstable), 32'd0);
      rst_n = 1'b1;
      wait_edges(2);

      // All races won: every bit 1, unanimous; done exactly at edge N.
      start_run(8'h00, M_ONE, 0);
      wait_edges(N - 1);
      check("busy_before_done", 32'(busy), 32'd1);
      wait_edges(1);
      check("done_at_N", 32'(done), 32'd1);
      check("busy_at_N", 32'(busy), 32'd0);
      finish_run(8'hFF, 8'h00);

      // Challenge walk from 0xF0 in steps of 0x3B.
      start_run(8'hF0, M_ZERO, 0);
      wait_edges(1 + BIT_LEN);
      check("challenge_k1", 32'(arb_challenge), 32'h2B);
      wait_edges(6 * BIT_LEN);
      check("challenge_k7", 32'(arb_challenge), 32'h8D);
      finish_run(8'h00, 8'h00);

      // Parity-of-challenge arbiter, seed 0x5A.
      start_run(8'h5A, M_PARITY, 0);
      finish_run(8'hDC, 8'h00);

      // Split votes on bit 2 only: 3 of 5, then 2 of 5.
      start_run(8'h33, M_NOISY, 3);
      finish_run(8'h04, 8'h04);
      start_run(8'h33, M_NOISY, 2);
      finish_run(8'h00, 8'h04);

      // Starts while busy are ignored; the first IDLE start is accepted.
      start_run(8'h33, M_NOISY, 3);
      pulse_at(10, 8'h77);
      pulse_at(248, 8'hC3);
      wait_edges(1);
      check("done_with_pulses", 32'(done), 32'd1);
      check("response_with_pulses", 32'(response), 32'h04);
      start_run(8'h5A, M_PARITY, 0);
      wait_edges(1);
      check("response_cleared", 32'(response), 32'h00);
      check("unstable_cleared", 32'(unstable), 32'h00);
      finish_run(8'hDC, 8'h00);

      // Asynchronous reset mid-run aborts everything at once.
      start_run(8'h11, M_ONE, 0);
      wait_edges(100);
      #1;
      model_on = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_launch", 32'(arb_launch), 32'd0);
      check("abort_challenge", 32'(arb_challenge), 32'd0);
      check("abort_response", 32'(response), 32'd0);
      check("abort_unstable", 32'(unstable), 32'd0);
      for (int i = 0; i < 3; i++) begin
         wait_edges(1);
         check("abort_no_done", 32'(done), 32'd0);
      end
      rst_n    = 1'b1;
      fin_chal = '0;
      fin_resp = '0;
      fin_unst = '0;
      wait_edges(1);
      check("idle_after_reset", 32'(busy), 32'd0);
      start_run(8'h00, M_ONE, 0);
      wait_edges(N);
      check("done_after_reset", 32'(done), 32'd1);
      finish_run(8'hFF, 8'h00);

      model_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
